// File: rtl/fivebit_8way_ternary_adder_if.sv
// rtl/fivebit_8way_ternary_adder_if.sv - operand/result bundle for the 8-way 5-bit ternary adder tree
interface fivebit_8way_ternary_adder_if;
  logic [4:0] A;
  logic [4:0] B;
  logic [4:0] C;
  logic [4:0] D;
  logic [4:0] E;
  logic [4:0] F;
  logic [4:0] G;
  logic [4:0] H;
  logic [7:0] O;

  // Source of operands, consumer of the reduced sum
  modport master (
    output A, B, C, D, E, F, G, H,
    input  O
  );

  // The adder itself
  modport slave (
    input  A, B, C, D, E, F, G, H,
    output O
  );
endinterface

// File: rtl/fivebit_8way_ternary_adder.sv
// rtl/fivebit_8way_ternary_adder.sv - two-stage pipelined sum of eight 5-bit operands via ternary adds
module fivebit_8way_ternary_adder (
  input  logic                           clk_i,
  input  logic                           rst_i,
  fivebit_8way_ternary_adder_if.slave    bus
);

  // Stage 1 partial sums: two 3-input groups (max 93) and one 2-input group (max 62)
  logic [6:0] s0_q;
  logic [6:0] s1_q;
  logic [6:0] s2_q;
  // Stage 2 result, max 8*31 = 248 so 8 bits cannot overflow
  logic [7:0] o_q;

  // Operands zero-extended to the stage-1 width so each ternary add keeps its carries
  logic [6:0] a_x, b_x, c_x, d_x, e_x, f_x, g_x, h_x;

  assign a_x = {2'b00, bus.A};
  assign b_x = {2'b00, bus.B};
  assign c_x = {2'b00, bus.C};
  assign d_x = {2'b00, bus.D};
  assign e_x = {2'b00, bus.E};
  assign f_x = {2'b00, bus.F};
  assign g_x = {2'b00, bus.G};
  assign h_x = {2'b00, bus.H};

  // Stage 1: one ternary add per group; reset flushes any in-flight partial sums
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s0_q <= a_x + b_x + c_x;
      s1_q <= d_x + e_x + f_x;
      s2_q <= g_x + h_x;
    end
  end

  // Stage 2: single ternary add of the three partial sums into the registered output
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      o_q <= '0;
    end else begin
      o_q <= {1'b0, s0_q} + {1'b0, s1_q} + {1'b0, s2_q};
    end
  end

  assign bus.O = o_q;

endmodule

// File: tb/tb_fivebit_8way_ternary_adder.sv
// tb/tb_fivebit_8way_ternary_adder.sv - directed self-checking bench for the 8-way ternary adder
module tb_fivebit_8way_ternary_adder;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fivebit_8way_ternary_adder_if bus ();

  fivebit_8way_ternary_adder dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set8(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d,
                      input logic [4:0] e, input logic [4:0] f, input logic [4:0] g, input logic [4:0] h);
    bus.A = a; bus.B = b; bus.C = c; bus.D = d;
    bus.E = e; bus.F = f; bus.G = g; bus.H = h;
  endtask

  task automatic set_all(input logic [4:0] v);
    set8(v, v, v, v, v, v, v, v);
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    checks++;
    assert (bus.O === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, bus.O, exp);
    end
  endtask

  initial begin
    logic [4:0] oh [8];

    // Reset: O cleared after first reset edge
    set_all(5'd0);
    rst_i = 1'b1;
    tick();
    chk("reset_edge", 8'd0);
    tick();
    chk("reset_hold", 8'd0);

    // Idle zeros for 25 cycles
    rst_i = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      chk($sformatf("zeros_%0d", i), 8'd0);
    end

    // Ramp k = 0..30, one per clock; O after edge j reflects inputs of iteration j-1
    for (int k = 0; k <= 32; k++) begin
      set_all((k <= 30) ? 5'(k) : 5'd0);
      tick();
      if (k >= 1 && k <= 31) chk($sformatf("ramp_%0d", k - 1), 8'(8 * (k - 1)));
    end

    // Maximum, then back to zero
    set_all(5'd31);
    tick();
    set_all(5'd0);
    tick();
    chk("all_31", 8'd248);
    tick();
    chk("all_31_then_0", 8'd0);

    // One-hot magnitude per input position (H alone exercises the 2-input group)
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) oh[j] = (i == j) ? 5'd31 : 5'd0;
      set8(oh[0], oh[1], oh[2], oh[3], oh[4], oh[5], oh[6], oh[7]);
      tick();
      set_all(5'd0);
      tick();
      chk($sformatf("onehot_%0d", i), 8'd31);
    end

    // Distinct values, reversed, mixed; back-to-back at full rate
    set8(5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8);
    tick();
    set8(5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1);
    tick();
    chk("distinct_1_8", 8'd36);
    set8(5'd31, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0);
    tick();
    chk("distinct_8_1", 8'd36);
    set_all(5'd0);
    tick();
    chk("mixed_31_0", 8'd124);

    // Ramp with a one-cycle reset mid-stream
    for (int k = 0; k < 6; k++) begin
      set_all(5'(k));
      tick();
      if (k >= 1) chk($sformatf("pre_rst_ramp_%0d", k - 1), 8'(8 * (k - 1)));
    end
    rst_i = 1'b1;
    set_all(5'd6);
    tick();
    chk("mid_rst_edge", 8'd0);
    rst_i = 1'b0;
    set_all(5'd7);
    tick();
    chk("mid_rst_flushed", 8'd0);
    for (int k = 8; k <= 13; k++) begin
      set_all(5'(k));
      tick();
      chk($sformatf("post_rst_ramp_%0d", k - 1), 8'(8 * (k - 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
